store_buffer: RTL and testbench

//  Store queue between core LSU issue logic and the wishbone store unit.

---
 rtl/store_buffer_if.sv | 32 +++
 rtl/store_buffer.sv | 107 ++++++++++
 tb/tb_store_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store request / store unit bus between core LSU, store buffer and wishbone store unit.
// master: the core and store-unit side (drives req_* and su_valid_i).
// slave: the store buffer (drives req_ready_o, misalign_o, empty_o and su_* head outputs).
interface store_buffer_if #(
    parameter int ADDR_W = 32
);
    // core -> buffer store request
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_data_i;
    logic [1:0]        req_size_i;
    // status
    logic              misalign_o;
    logic              empty_o;
    // buffer head -> store unit
    logic              su_write_o;
    logic [ADDR_W-1:0] su_addr_o;
    logic [31:0]       su_data_o;
    logic [3:0]        su_we_o;
    logic              su_valid_i;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_size_i, su_valid_i,
        input  req_ready_o, misalign_o, empty_o, su_write_o, su_addr_o, su_data_o, su_we_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_size_i, su_valid_i,
        output req_ready_o, misalign_o, empty_o, su_write_o, su_addr_o, su_data_o, su_we_o
    );
endinterface

// File: rtl/store_buffer.sv
// Store queue: aligns byte/half/word stores into lanes + byte enables, FIFOs them to the store unit.
// Latency: a store pushed into an empty buffer is on su_* the next cycle; pop-to-next-head is 1 cycle.
// Backpressure: req_ready_o drops only when DEPTH entries are held (registered count, no su_valid_i path).
//
// Ports: clk, rstn_i (async active-low), bus (store_buffer_if.slave):
//   req_valid_i/req_ready_o/req_addr_i/req_data_i/req_size_i  store request handshake
//   misalign_o  one-cycle pulse after an accepted illegal store; empty_o  nothing pending
//   su_write_o/su_addr_o/su_data_o/su_we_o  FIFO head; su_valid_i  store-unit completion
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rstn_i,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage needs no reset: the head outputs are gated by su_write_o.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [3:0]        we_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          misalign_q;

    logic [1:0]  a;
    logic        legal;
    logic [3:0]  lane_we;
    logic [31:0] lane_dat;
    logic        push;
    logic        enq;
    logic        pop;

    assign a = bus.req_addr_i[1:0];

    // Lane placement: data is replicated across lanes so the enabled lanes
    // always carry the right bytes regardless of the offset.
    always_comb begin
        legal    = 1'b0;
        lane_we  = 4'b0000;
        lane_dat = 32'h0;
        case (bus.req_size_i)
            2'b00: begin
                legal    = 1'b1;
                lane_we  = 4'b0001 << a;
                lane_dat = {4{bus.req_data_i[7:0]}};
            end
            2'b01: begin
                legal    = ~a[0];
                lane_we  = 4'b0011 << a;
                lane_dat = {2{bus.req_data_i[15:0]}};
            end
            2'b10: begin
                legal    = (a == 2'b00);
                lane_we  = 4'b1111;
                lane_dat = bus.req_data_i;
            end
            default: begin
                legal    = 1'b0;
                lane_we  = 4'b0000;
                lane_dat = 32'h0;
            end
        endcase
    end

    // An illegal store still completes its handshake; it is just not enqueued.
    assign push = bus.req_valid_i & bus.req_ready_o;
    assign enq  = push & legal;
    assign pop  = bus.su_write_o & bus.su_valid_i;

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
            data_mem[wr_ptr] <= lane_dat;
            we_mem[wr_ptr]   <= lane_we;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + CW'(enq) - CW'(pop);
            misalign_q <= push & ~legal;
        end
    end

    // All status comes from registered count, so a full buffer cannot accept
    // in the same cycle it pops and su_write_o drops with the async reset.
    assign bus.req_ready_o = (count != FULL_CNT);
    assign bus.empty_o     = (count == '0);
    assign bus.su_write_o  = ~bus.empty_o;
    assign bus.misalign_o  = misalign_q;
    assign bus.su_addr_o   = bus.su_write_o ? addr_mem[rd_ptr] : '0;
    assign bus.su_data_o   = bus.su_write_o ? data_mem[rd_ptr] : 32'h0;
    assign bus.su_we_o     = bus.su_write_o ? we_mem[rd_ptr]   : 4'h0;
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(32)) bus ();

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk    (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } entry_t;

    entry_t q[$];
    logic   exp_mis;

    function automatic bit is_legal(input logic [31:0] addr, input logic [1:0] size);
        int off = int'(addr % 4);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return (off % 2) == 0;
            2'd2:    return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic entry_t make_entry(input logic [31:0] addr, input logic [31:0] d,
                                          input logic [1:0] size);
        entry_t e;
        int off = int'(addr % 4);
        e.addr = addr - 32'(off);
        case (size)
            2'd0: begin e.we = 4'(1 << off); e.data = 32'(d[7:0])  * 32'h01010101; end
            2'd1: begin e.we = 4'(3 << off); e.data = 32'(d[15:0]) * 32'h00010001; end
            default: begin e.we = 4'hF; e.data = d; end
        endcase
        return e;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            exp_mis = 1'b0;
        end else begin
            bit acc;
            bit leg;
            entry_t ne;
            acc = bus.req_valid_i && (q.size() < 4);
            leg = is_legal(bus.req_addr_i, bus.req_size_i);
            ne  = make_entry(bus.req_addr_i, bus.req_data_i, bus.req_size_i);
            if (bus.su_valid_i && q.size() > 0) void'(q.pop_front());
            if (acc && leg) q.push_back(ne);
            exp_mis = acc && !leg;
        end
    end

    always @(negedge clk) begin
        entry_t h;
        h.addr = 32'h0; h.data = 32'h0; h.we = 4'h0;
        if (q.size() > 0) h = q[0];
        check("req_ready", 64'(bus.req_ready_o), 64'(q.size() < 4));
        check("empty",     64'(bus.empty_o),     64'(q.size() == 0));
        check("su_write",  64'(bus.su_write_o),  64'(q.size() != 0));
        check("misalign",  64'(bus.misalign_o),  64'(exp_mis));
        check("su_addr",   64'(bus.su_addr_o),   64'(h.addr));
        check("su_data",   64'(bus.su_data_o),   64'(h.data));
        check("su_we",     64'(bus.su_we_o),     64'(h.we));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] ad, input logic [31:0] d,
                         input logic [1:0] sz);
        bus.req_valid_i = v;
        bus.req_addr_i  = ad;
        bus.req_data_i  = d;
        bus.req_size_i  = sz;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    initial begin
        logic [31:0] ill_addr [3];
        logic [1:0]  ill_size [3];
        ill_addr[0] = 32'h2001; ill_size[0] = 2'd2;
        ill_addr[1] = 32'h2003; ill_size[1] = 2'd1;
        ill_addr[2] = 32'h2000; ill_size[2] = 2'd3;

        rstn = 1'b0;
        idle();
        bus.su_valid_i = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_ready",    64'(bus.req_ready_o), 64'd1);
        check("rst_empty",    64'(bus.empty_o),     64'd1);
        check("rst_su_write", 64'(bus.su_write_o),  64'd0);
        check("rst_su_addr",  64'(bus.su_addr_o),   64'd0);

        // 1) word store, then pop
        drive(1'b1, 32'h1000, 32'hDEADBEEF, 2'd2);
        tick();
        idle();
        check("t1_su_write", 64'(bus.su_write_o), 64'd1);
        check("t1_su_addr",  64'(bus.su_addr_o),  64'h1000);
        check("t1_su_we",    64'(bus.su_we_o),    64'hF);
        check("t1_su_data",  64'(bus.su_data_o),  64'hDEADBEEF);
        bus.su_valid_i = 1'b1;
        tick();
        bus.su_valid_i = 1'b0;
        check("t1_empty", 64'(bus.empty_o), 64'd1);

        // 2) byte and half lane placement
        drive(1'b1, 32'h2003, 32'h000000A5, 2'd0);
        tick();
        idle();
        check("t2_byte_we",   64'(bus.su_we_o),   64'h8);
        check("t2_byte_data", 64'(bus.su_data_o), 64'hA5A5A5A5);
        check("t2_byte_addr", 64'(bus.su_addr_o), 64'h2000);
        bus.su_valid_i = 1'b1;
        tick();
        bus.su_valid_i = 1'b0;
        drive(1'b1, 32'h2002, 32'h00001234, 2'd1);
        tick();
        idle();
        check("t2_half_we",   64'(bus.su_we_o),   64'hC);
        check("t2_half_data", 64'(bus.su_data_o), 64'h12341234);
        bus.su_valid_i = 1'b1;
        tick();
        bus.su_valid_i = 1'b0;

        // 3) illegal stores pulse misalign once, enqueue nothing
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ill_addr[i], 32'hCAFEF00D, ill_size[i]);
            tick();
            idle();
            check("t3_mis_pulse", 64'(bus.misalign_o), 64'd1);
            check("t3_empty",     64'(bus.empty_o),    64'd1);
            check("t3_su_write",  64'(bus.su_write_o), 64'd0);
            tick();
            check("t3_mis_clear", 64'(bus.misalign_o), 64'd0);
        end

        // 4) fill, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 2'd2);
            tick();
        end
        idle();
        check("t4_full", 64'(bus.req_ready_o), 64'd0);
        bus.su_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_head_write", 64'(bus.su_write_o), 64'd1);
            check("t4_head_addr",  64'(bus.su_addr_o),  64'(32'h3000 + 32'(4 * i)));
            tick();
            if (i == 0) check("t4_ready_after_pop", 64'(bus.req_ready_o), 64'd1);
        end
        bus.su_valid_i = 1'b0;
        check("t4_empty", 64'(bus.empty_o), 64'd1);

        // 5) steady count of 2 with simultaneous push/pop, wrapping pointers
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h5000 + 32'(4 * i), $urandom, 2'd2);
            tick();
        end
        bus.su_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h5008 + 32'(4 * i), $urandom, 2'd2);
            tick();
            check("t5_head_addr", 64'(bus.su_addr_o), 64'(32'h5000 + 32'(4 * (i + 1))));
            check("t5_not_full",  64'(bus.req_ready_o), 64'd1);
        end
        idle();
        repeat (2) tick();
        bus.su_valid_i = 1'b0;
        check("t5_empty", 64'(bus.empty_o), 64'd1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 16'hFFFF)), $urandom,
                  2'($urandom_range(0, 3)));
            bus.su_valid_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle();
        bus.su_valid_i = 1'b0;

        // 6) async reset with entries queued
        bus.su_valid_i = 1'b1;
        repeat (5) tick();
        bus.su_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 2'd2);
            tick();
        end
        idle();
        check("t6_pre_write", 64'(bus.su_write_o), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_async_write", 64'(bus.su_write_o), 64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        check("t6_empty", 64'(bus.empty_o),     64'd1);
        check("t6_ready", 64'(bus.req_ready_o), 64'd1);
        check("t6_write", 64'(bus.su_write_o),  64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
